// File: rtl/ring_counter.sv
`default_nettype none
// ============================================================================
// Module      : ring_counter
// Description : Free-running one-hot ring counter. A single '1' circulates
//               through a WIDTH-bit register. Each rising clock edge moves it
//               one stage. The counter also provides a registered binary
//               index of the set bit and a wrap indicator.
// Parameters  : WIDTH    - number of ring stages (2..32)
//               INIT_POS - bit index loaded on reset (0..WIDTH-1)
//               DIR_LEFT - 1: rotate toward MSB, 0: rotate toward LSB
// Ports       : clk   - rising-edge clock
//               reset - asynchronous active-high reset
//               q     - one-hot ring state (registered)
//               pos   - index of the set bit in q (registered)
//               wrap  - next edge moves the '1' from end stage to start stage
//               err   - illegal-state flag (registered, self-correct build)
// Options     : RING_COUNTER_SELF_CORRECT_EN - when defined, a non-one-hot
//               state is replaced by the reset pattern on the next edge and
//               err pulses for one cycle. Otherwise q is a pure rotation.
// Revision    : 1.0 - initial release
// ============================================================================
module ring_counter #(
  parameter int WIDTH    = 4,
  parameter int INIT_POS = 0,
  parameter int DIR_LEFT = 1,
  localparam int PW      = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] q,
  output logic [PW-1:0]    pos,
  output logic             wrap,
  output logic             err
);

  localparam logic [WIDTH-1:0] c_one     = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_q_rst   = c_one << INIT_POS;
  localparam logic [PW-1:0]    c_pos_rst = PW'(INIT_POS);

  logic [WIDTH-1:0] r_q;
  logic [PW-1:0]    r_pos;
  logic [WIDTH-1:0] w_q_rot;
  logic             w_wrap;

  // Rotation and end-stage detection depend only on direction.
  generate
    if (DIR_LEFT != 0) begin : g_left
      assign w_q_rot = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
      assign w_wrap  = r_q[WIDTH-1];
    end else begin : g_right
      assign w_q_rot = {r_q[0], r_q[WIDTH-1:1]};
      assign w_wrap  = r_q[0];
    end
  endgenerate

`ifdef RING_COUNTER_SELF_CORRECT_EN
  localparam logic [PW-1:0] c_pos_one = PW'(1);
  localparam logic [PW-1:0] c_pos_end = PW'(WIDTH - 1);

  logic          r_err;
  logic          w_onehot;
  logic [PW-1:0] w_pos_nxt;

  // x & (x-1) clears the lowest set bit: zero result means at most one bit.
  assign w_onehot = (r_q != '0) && ((r_q & (r_q - c_one)) == '0);

  // pos tracks the ring arithmetically, wrapping modulo WIDTH (WIDTH need
  // not be a power of two).
  generate
    if (DIR_LEFT != 0) begin : g_pos_inc
      assign w_pos_nxt = (r_pos == c_pos_end) ? '0 : r_pos + c_pos_one;
    end else begin : g_pos_dec
      assign w_pos_nxt = (r_pos == '0) ? c_pos_end : r_pos - c_pos_one;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q   <= c_q_rst;
      r_pos <= c_pos_rst;
      r_err <= 1'b0;
    end else if (!w_onehot) begin
      // Recover from a corrupted ring by reloading the reset pattern.
      r_q   <= c_q_rst;
      r_pos <= c_pos_rst;
      r_err <= 1'b1;
    end else begin
      r_q   <= w_q_rot;
      r_pos <= w_pos_nxt;
      r_err <= 1'b0;
    end
  end

  assign err = r_err;
`else
  logic [PW-1:0] w_low;

  // Lowest set bit of the next state; scanning downward lets the lowest
  // index win. An all-zero ring reports index 0.
  always_comb begin
    w_low = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (w_q_rot[i]) begin
        w_low = PW'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q   <= c_q_rst;
      r_pos <= c_pos_rst;
    end else begin
      r_q   <= w_q_rot;
      r_pos <= w_low;
    end
  end

  assign err = 1'b0;
`endif

  assign q    = r_q;
  assign pos  = r_pos;
  assign wrap = w_wrap;

endmodule
`default_nettype wire

// File: tb/tb_ring_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ring_counter
// Description : Self-checking bench for ring_counter. It uses two instances:
//               a default 4-stage left ring and an 8-stage right ring that
//               starts at bit 3. A position-index model predicts the outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ring_counter;

  logic       clk = 1'b0;
  logic       r4;
  logic       r8;
  logic [3:0] q4;
  logic [1:0] pos4;
  logic       wrap4;
  logic       err4;
  logic [7:0] q8;
  logic [2:0] pos8;
  logic       wrap8;
  logic       err8;

  int total = 0;
  int bad   = 0;
  int p4;
  int p8;

  always #5 clk = ~clk;

  ring_counter #(.WIDTH(4), .INIT_POS(0), .DIR_LEFT(1)) dut4 (
    .clk(clk), .reset(r4), .q(q4), .pos(pos4), .wrap(wrap4), .err(err4)
  );

  ring_counter #(.WIDTH(8), .INIT_POS(3), .DIR_LEFT(0)) dut8 (
    .clk(clk), .reset(r8), .q(q8), .pos(pos8), .wrap(wrap8), .err(err8)
  );

  // Model: each ring is only the index of its '1'. The outputs follow from
  // that index. The 4-stage ring ends at stage 3, and the 8-stage ring
  // rotates right, so its end stage is 0.
  function automatic logic [7:0] exp4();
    return {4'(1 << p4), 2'(p4), (p4 == 3), 1'b0};
  endfunction

  function automatic logic [12:0] exp8();
    return {8'(1 << p8), 3'(p8), (p8 == 0), 1'b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!r4) p4 = (p4 + 1) % 4;
    if (!r8) p8 = (p8 + 7) % 8;
    #1;
  endtask

  task automatic test_reset();
    r4 = 1'b1; r8 = 1'b1; p4 = 0; p8 = 3;
    #1;
    total++;
    if ({q4, pos4, wrap4, err4} !== exp4()) begin
      bad++; $display("FAIL reset4 got=%b exp=%b", {q4, pos4, wrap4, err4}, exp4());
    end
    total++;
    if ({q8, pos8, wrap8, err8} !== exp8()) begin
      bad++; $display("FAIL reset8 got=%b exp=%b", {q8, pos8, wrap8, err8}, exp8());
    end
    #6; // past the edge at 5ns; reset must still hold the outputs
    total++;
    if ({q4, pos4, wrap4, err4} !== 8'b0001_00_0_0) begin
      bad++; $display("FAIL reset4_hold got=%b exp=%b", {q4, pos4, wrap4, err4}, 8'b0001_00_0_0);
    end
    total++;
    if ({q8, pos8, wrap8, err8} !== 13'b00001000_011_0_0) begin
      bad++; $display("FAIL reset8_hold got=%b exp=%b", {q8, pos8, wrap8, err8}, 13'b00001000_011_0_0);
    end
    #3;
    r4 = 1'b0; r8 = 1'b0; // released at 10ns
  endtask

  task automatic test_free_run();
    for (int i = 0; i < 9; i++) begin
      tick();
      total++;
      if ({q4, pos4, wrap4, err4} !== exp4()) begin
        bad++; $display("FAIL run4[%0d] got=%b exp=%b", i, {q4, pos4, wrap4, err4}, exp4());
      end
      total++;
      if ({q8, pos8, wrap8, err8} !== exp8()) begin
        bad++; $display("FAIL run8[%0d] got=%b exp=%b", i, {q8, pos8, wrap8, err8}, exp8());
      end
    end
  endtask

  task automatic test_async_reset();
    int n;
    int which;
    int h;
    // Directed case: hit the 4-stage ring while it holds 0100.
    for (int i = 0; i < 4 && p4 != 2; i++) tick();
    total++;
    if (q4 !== 4'b0100) begin
      bad++; $display("FAIL pre_reset4 got=%b exp=%b", q4, 4'b0100);
    end
    #3; r4 = 1'b1; p4 = 0; #1;
    total++;
    if ({q4, pos4, wrap4, err4} !== 8'b0001_00_0_0) begin
      bad++; $display("FAIL async4 got=%b exp=%b", {q4, pos4, wrap4, err4}, 8'b0001_00_0_0);
    end
    #2; r4 = 1'b0;
    tick();
    total++;
    if ({q4, pos4, wrap4, err4} !== 8'b0010_01_0_0) begin
      bad++; $display("FAIL resume4 got=%b exp=%b", {q4, pos4, wrap4, err4}, 8'b0010_01_0_0);
    end
    // Randomized resets at random points and phases.
    for (int k = 0; k < 20; k++) begin
      n = $urandom_range(0, 6);
      repeat (n) begin
        tick();
        total++;
        if ({q4, pos4, wrap4, err4} !== exp4()) begin
          bad++; $display("FAIL rnd4[%0d] got=%b exp=%b", k, {q4, pos4, wrap4, err4}, exp4());
        end
        total++;
        if ({q8, pos8, wrap8, err8} !== exp8()) begin
          bad++; $display("FAIL rnd8[%0d] got=%b exp=%b", k, {q8, pos8, wrap8, err8}, exp8());
        end
      end
      which = $urandom_range(1, 3);
      #($urandom_range(1, 3));
      if (which[0]) begin r4 = 1'b1; p4 = 0; end
      if (which[1]) begin r8 = 1'b1; p8 = 3; end
      #1;
      total++;
      if ({q4, pos4, wrap4, err4} !== exp4()) begin
        bad++; $display("FAIL arst4[%0d] got=%b exp=%b", k, {q4, pos4, wrap4, err4}, exp4());
      end
      total++;
      if ({q8, pos8, wrap8, err8} !== exp8()) begin
        bad++; $display("FAIL arst8[%0d] got=%b exp=%b", k, {q8, pos8, wrap8, err8}, exp8());
      end
      h = $urandom_range(0, 2);
      repeat (h) begin
        tick();
        total++;
        if ({q4, pos4, wrap4, err4, q8, pos8, wrap8, err8} !== {exp4(), exp8()}) begin
          bad++; $display("FAIL hold[%0d] got=%b exp=%b", k,
                          {q4, pos4, wrap4, err4, q8, pos8, wrap8, err8}, {exp4(), exp8()});
        end
      end
      #2; r4 = 1'b0; r8 = 1'b0;
    end
  endtask

  task automatic test_illegal();
    logic [3:0] v;
    logic [3:0] rot;
    logic [1:0] lo;
    for (int k = 0; k < 6; k++) begin
      v = (k == 0) ? 4'b0110 : 4'($urandom_range(0, 15));
      if ($countones(v) == 1) v = 4'b0000;
      #1;
      force dut4.r_q = v;
      #1;
      release dut4.r_q;
      #1;
      total++;
      if ({q4, wrap4} !== {v, v[3]}) begin
        bad++; $display("FAIL inject[%0d] got=%b exp=%b", k, {q4, wrap4}, {v, v[3]});
      end
      tick();
`ifdef RING_COUNTER_SELF_CORRECT_EN
      p4 = 0;
      total++;
      if ({q4, pos4, wrap4, err4} !== 8'b0001_00_0_1) begin
        bad++; $display("FAIL correct[%0d] got=%b exp=%b", k, {q4, pos4, wrap4, err4}, 8'b0001_00_0_1);
      end
      tick();
      total++;
      if ({q4, pos4, wrap4, err4} !== exp4()) begin
        bad++; $display("FAIL after_correct[%0d] got=%b exp=%b", k, {q4, pos4, wrap4, err4}, exp4());
      end
`else
      rot = {v[2:0], v[3]};
      lo  = 2'd0;
      for (int i = 3; i >= 0; i--) if (rot[i]) lo = 2'(i);
      total++;
      if ({q4, pos4, wrap4, err4} !== {rot, lo, rot[3], 1'b0}) begin
        bad++; $display("FAIL rotate_bad[%0d] got=%b exp=%b", k, {q4, pos4, wrap4, err4},
                        {rot, lo, rot[3], 1'b0});
      end
      #2; r4 = 1'b1; p4 = 0; #2; r4 = 1'b0;
      tick();
      total++;
      if ({q4, pos4, wrap4, err4} !== exp4()) begin
        bad++; $display("FAIL recover[%0d] got=%b exp=%b", k, {q4, pos4, wrap4, err4}, exp4());
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_async_reset();
    test_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
